// File: rtl/store_sequencer_pkg.sv
// Shared store-op encodings and helpers for the store sequencer and AMO path.
package store_sequencer_pkg;

  // Store operation encoding as produced by the store-type decoder.
  localparam int STORE_OP_WIDTH = 2;
  localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SB = 2'd0;
  localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SH = 2'd1;
  localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SW = 2'd2;

  // Right-aligned byte-enable pattern for an op; unknown ops behave as SW.
  function automatic logic [3:0] store_base_strb(input logic [STORE_OP_WIDTH-1:0] op);
    case (op)
      STORE_OP_SB: store_base_strb = 4'b0001;
      STORE_OP_SH: store_base_strb = 4'b0011;
      default:     store_base_strb = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Maps (op, byte offset, right-aligned data) onto an 8-lane strobe and 64-bit
// data image spanning two consecutive words. Purely combinational.
module store_lane_align
  import store_sequencer_pkg::*;
(
  input  logic [STORE_OP_WIDTH-1:0] i_op,
  input  logic [1:0]                i_offset,
  input  logic [31:0]               i_wdata,
  output logic [7:0]                o_strb,
  output logic [63:0]               o_data
);

  logic [3:0]  w_base_strb;
  logic [31:0] w_mask;

  // Build the byte mask from the op, then shift strobe and masked data into lanes.
  always_comb begin
    w_base_strb = store_base_strb(i_op);
    w_mask      = {{8{w_base_strb[3]}}, {8{w_base_strb[2]}},
                   {8{w_base_strb[1]}}, {8{w_base_strb[0]}}};
    o_strb      = {4'b0000, w_base_strb} << i_offset;
    o_data      = {32'h0, i_wdata & w_mask} << {i_offset, 3'b000};
  end

endmodule

// File: rtl/store_sequencer.sv
// Turns one store request into one or two word-aligned bus beats. Stores that
// cross a word boundary are split into two beats or rejected, per SPLIT_EN.
module store_sequencer
  import store_sequencer_pkg::*;
#(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  input  logic [STORE_OP_WIDTH-1:0] req_op,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [31:0]               mem_addr,
  output logic [31:0]               mem_wdata,
  output logic [3:0]                mem_wstrb,
  output logic                      done,
  output logic                      misaligned_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BEAT0 = 3'd1,
    S_BEAT1 = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_strb;
  logic [63:0] r_data;
  logic [31:0] r_waddr;
  logic [7:0]  w_strb;
  logic [63:0] w_data;
  logic        w_accept;
  logic        w_straddle_in;
  logic        w_straddle;

  store_lane_align u_align (
    .i_op     (req_op),
    .i_offset (req_addr[1:0]),
    .i_wdata  (req_wdata),
    .o_strb   (w_strb),
    .o_data   (w_data)
  );

  assign w_accept      = req_valid && (r_state == S_IDLE);
  assign w_straddle_in = |w_strb[7:4];
  assign w_straddle    = |r_strb[7:4];

  // State register; reset drops any partially issued store.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Capture the lane-aligned request at acceptance so bus outputs stay stable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_strb  <= 8'h0;
      r_data  <= 64'h0;
      r_waddr <= 32'h0;
    end else if (w_accept) begin
      r_strb  <= w_strb;
      r_data  <= w_data;
      r_waddr <= {req_addr[31:2], 2'b00};
    end
  end

  // Next-state and output decode; bus fields are zero whenever no beat is valid.
  always_comb begin
    w_state_next   = r_state;
    req_ready      = 1'b0;
    mem_valid      = 1'b0;
    mem_addr       = 32'h0;
    mem_wdata      = 32'h0;
    mem_wstrb      = 4'h0;
    done           = 1'b0;
    misaligned_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_straddle_in && !SPLIT_EN) w_state_next = S_ERR;
          else                            w_state_next = S_BEAT0;
        end
      end
      S_BEAT0: begin
        mem_valid = 1'b1;
        mem_addr  = r_waddr;
        mem_wstrb = r_strb[3:0];
        mem_wdata = r_data[31:0];
        if (mem_ready) w_state_next = w_straddle ? S_BEAT1 : S_DONE;
      end
      S_BEAT1: begin
        mem_valid = 1'b1;
        mem_addr  = r_waddr + 32'd4;  // wraps past the top of the address space
        mem_wstrb = r_strb[7:4];
        mem_wdata = r_data[63:32];
        if (mem_ready) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      S_ERR: begin
        misaligned_err = 1'b1;
        w_state_next   = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule
